config_buf_writer: RTL and testbench

Command-driven writer for the 40x23 tile-index buffer that the menu renderer scans out. Accepts draw commands from the menu controller (clear screen, put one tile, copy a string from the string ROM, print an 8-bit value in decimal) and turns each into a stream of single-byte writes on the buffer's write port. It is the producer side of the buffer whose consumer reads one tile index per 32x32 screen cell.

---
 rtl/config_pkg.sv | 38 +++
 rtl/config_bin2dec.sv | 83 ++++++++
 rtl/config_buf_writer.sv | 242 ++++++++++++++++++++++++
 tb/tb_config_buf_writer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/config_pkg.sv
// Shared types and geometry for the 40x23 menu tile buffer writer.
// Holds opcodes, FSM state encodings and the row/column to address mapping.
package config_pkg;

    typedef enum logic [1:0] {
        OP_CLEAR  = 2'd0,
        OP_PUT    = 2'd1,
        OP_STRING = 2'd2,
        OP_DEC    = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_PUT,
        S_STR,
        S_DEC_CONV,
        S_DEC_WR
    } state_e;

    typedef enum logic [1:0] {
        B_IDLE,
        B_HUND,
        B_TENS
    } b2d_state_e;

    localparam logic [6:0] BUF_COLS  = 7'd40;
    localparam logic [4:0] BUF_ROWS  = 5'd23;
    localparam logic [9:0] BUF_DEPTH = 10'd920;

    // 40*row + col built from shifts so no multiplier is inferred.
    function automatic logic [9:0] buf_addr(input logic [4:0] row, input logic [6:0] col);
        logic [9:0] r;
        r = {5'b0, row};
        return (r << 5) + (r << 3) + {3'b0, col};
    endfunction

endpackage

// File: rtl/config_bin2dec.sv
// Sequential 8-bit binary to three-digit BCD converter.
// Subtracts 100 until below, then 10 until below; at most 12 cycles per value.
module config_bin2dec
    import config_pkg::*;
(
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic       start_in,
    input  logic [7:0] value_in,
    output logic       done_out,
    output logic [3:0] hundreds_out,
    output logic [3:0] tens_out,
    output logic [3:0] ones_out
);

    b2d_state_e state_q, state_d;
    logic       done_q, done_d;
    logic [7:0] val_q, val_d;
    logic [3:0] hund_q, hund_d;
    logic [3:0] tens_q, tens_d;
    logic [3:0] ones_q, ones_d;

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        val_d   = val_q;
        hund_d  = hund_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        case (state_q)
            B_IDLE: begin
                if (start_in) begin
                    val_d   = value_in;
                    hund_d  = 4'd0;
                    tens_d  = 4'd0;
                    state_d = B_HUND;
                end
            end
            B_HUND: begin
                if (val_q >= 8'd100) begin
                    val_d  = val_q - 8'd100;
                    hund_d = hund_q + 4'd1;
                end else begin
                    state_d = B_TENS;
                end
            end
            B_TENS: begin
                if (val_q >= 8'd10) begin
                    val_d  = val_q - 8'd10;
                    tens_d = tens_q + 4'd1;
                end else begin
                    ones_d  = val_q[3:0];
                    done_d  = 1'b1;
                    state_d = B_IDLE;
                end
            end
            default: state_d = B_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q <= B_IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk_in) begin
        val_q  <= val_d;
        hund_q <= hund_d;
        tens_q <= tens_d;
        ones_q <= ones_d;
    end

    assign done_out     = done_q;
    assign hundreds_out = hund_q;
    assign tens_out     = tens_q;
    assign ones_out     = ones_q;

endmodule

// File: rtl/config_buf_writer.sv
// Turns menu draw commands (CLEAR/PUT/STRING/DEC) into single-byte writes
// on the 40x23 tile buffer write port; every output is a flop.
module config_buf_writer
    import config_pkg::*;
#(
    parameter int          STR_ROM_LATENCY = 2,
    parameter logic [7:0]  BLANK_TILE      = 8'h20
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic       cmd_valid_in,
    output logic       cmd_ready_out,
    input  logic [1:0] cmd_op_in,
    input  logic [4:0] cmd_row_in,
    input  logic [5:0] cmd_col_in,
    input  logic [9:0] cmd_arg_in,
    input  logic [5:0] cmd_len_in,
    output logic [9:0] str_addr_out,
    input  logic [7:0] str_data_in,
    output logic [9:0] buf_write_addr_out,
    output logic [7:0] buf_write_data_out,
    output logic       buf_write_en_out,
    output logic       done_out
);

    localparam int L = STR_ROM_LATENCY;

    state_e     state_q, state_d;
    logic       ready_q, ready_d;
    logic       wen_q, wen_d;
    logic [9:0] waddr_q, waddr_d;
    logic [7:0] wdata_q, wdata_d;
    logic       done_q, done_d;
    logic [9:0] str_addr_q, str_addr_d;
    logic [9:0] cnt_q, cnt_d;
    logic [4:0] row_q, row_d;
    logic [5:0] col_q, col_d;
    logic [9:0] arg_q, arg_d;
    logic [5:0] len_q, len_d;
    logic       oob_q, oob_d;

    // Column and valid travel alongside the ROM read so the returned byte lands in the right cell.
    logic [L-1:0]       sv_q, sv_d;
    logic [L-1:0][6:0]  scol_q, scol_d;
    logic [L-1:0]       sv_older;

    logic       accept;
    logic       cmd_oob;
    logic       b2d_start;
    logic       b2d_done;
    logic [3:0] dig_h, dig_t, dig_o;
    logic [6:0] dec_col;
    logic [7:0] dec_tile;

    function automatic logic [7:0] ascii_digit(input logic [3:0] d);
        return 8'h30 + {4'h0, d};
    endfunction

    config_bin2dec u_bin2dec (
        .clk_in       (clk_in),
        .rst_n_in     (rst_n_in),
        .start_in     (b2d_start),
        .value_in     (arg_q[7:0]),
        .done_out     (b2d_done),
        .hundreds_out (dig_h),
        .tens_out     (dig_t),
        .ones_out     (dig_o)
    );

    assign accept  = cmd_valid_in && ready_q;
    assign cmd_oob = (cmd_row_in >= BUF_ROWS) || ({1'b0, cmd_col_in} >= BUF_COLS);

    // Leading zeros of hundreds and tens print as blanks; ones always prints.
    always_comb begin
        dec_col  = {1'b0, col_q} + {5'b0, cnt_q[1:0]};
        dec_tile = ascii_digit(dig_o);
        case (cnt_q[1:0])
            2'd0:    dec_tile = (dig_h == 4'd0) ? BLANK_TILE : ascii_digit(dig_h);
            2'd1:    dec_tile = (dig_h == 4'd0 && dig_t == 4'd0) ? BLANK_TILE : ascii_digit(dig_t);
            default: dec_tile = ascii_digit(dig_o);
        endcase
    end

    always_comb begin
        state_d    = state_q;
        wen_d      = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        done_d     = 1'b0;
        str_addr_d = str_addr_q;
        cnt_d      = cnt_q;
        row_d      = row_q;
        col_d      = col_q;
        arg_d      = arg_q;
        len_d      = len_q;
        oob_d      = oob_q;
        b2d_start  = 1'b0;
        for (int k = L - 1; k > 0; k--) begin
            sv_d[k]   = sv_q[k-1];
            scol_d[k] = scol_q[k-1];
        end
        sv_d[0]   = 1'b0;
        scol_d[0] = scol_q[0];
        sv_older  = sv_q;
        sv_older[L-1] = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    row_d = cmd_row_in;
                    col_d = cmd_col_in;
                    arg_d = cmd_arg_in;
                    len_d = cmd_len_in;
                    oob_d = cmd_oob;
                    cnt_d = 10'd0;
                    case (op_e'(cmd_op_in))
                        OP_CLEAR: begin
                            wen_d   = 1'b1;
                            waddr_d = 10'd0;
                            wdata_d = BLANK_TILE;
                            cnt_d   = 10'd1;
                            state_d = S_CLEAR;
                        end
                        OP_PUT: begin
                            wen_d   = !cmd_oob;
                            waddr_d = buf_addr(cmd_row_in, {1'b0, cmd_col_in});
                            wdata_d = cmd_arg_in[7:0];
                            done_d  = 1'b1;
                            state_d = S_PUT;
                        end
                        OP_STRING: begin
                            state_d = S_STR;
                            if (cmd_len_in != 6'd0) begin
                                sv_d[0]    = 1'b1;
                                scol_d[0]  = {1'b0, cmd_col_in};
                                str_addr_d = cmd_arg_in;
                                cnt_d      = 10'd1;
                            end else begin
                                done_d = 1'b1;
                            end
                        end
                        default: begin
                            state_d = S_DEC_CONV;
                        end
                    endcase
                end
            end
            S_CLEAR: begin
                if (cnt_q == BUF_DEPTH) begin
                    state_d = S_IDLE;
                end else begin
                    wen_d   = 1'b1;
                    waddr_d = cnt_q;
                    wdata_d = BLANK_TILE;
                    done_d  = (cnt_q == BUF_DEPTH - 10'd1);
                    cnt_d   = cnt_q + 10'd1;
                end
            end
            S_PUT: state_d = S_IDLE;
            S_STR: begin
                if (cnt_q < {4'b0, len_q}) begin
                    sv_d[0]    = 1'b1;
                    scol_d[0]  = {1'b0, col_q} + cnt_q[6:0];
                    str_addr_d = arg_q + cnt_q;
                    cnt_d      = cnt_q + 10'd1;
                end
                if (sv_q[L-1]) begin
                    wen_d   = !oob_q && (scol_q[L-1] < BUF_COLS);
                    waddr_d = buf_addr(row_q, scol_q[L-1]);
                    wdata_d = str_data_in;
                    done_d  = (cnt_q == {4'b0, len_q}) && (sv_older == '0);
                end
                if (cnt_q == {4'b0, len_q} && sv_q == '0)
                    state_d = S_IDLE;
            end
            S_DEC_CONV: begin
                // Start is issued here so the converter sees the latched value.
                b2d_start = (cnt_q == 10'd0);
                cnt_d     = 10'd1;
                if (b2d_done) begin
                    cnt_d   = 10'd0;
                    state_d = S_DEC_WR;
                end
            end
            S_DEC_WR: begin
                if (cnt_q == 10'd3) begin
                    state_d = S_IDLE;
                end else begin
                    wen_d   = !oob_q && (dec_col < BUF_COLS);
                    waddr_d = buf_addr(row_q, dec_col);
                    wdata_d = dec_tile;
                    done_d  = (cnt_q == 10'd2);
                    cnt_d   = cnt_q + 10'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q    <= S_IDLE;
            ready_q    <= 1'b0;
            wen_q      <= 1'b0;
            waddr_q    <= 10'd0;
            wdata_q    <= 8'd0;
            done_q     <= 1'b0;
            str_addr_q <= 10'd0;
            cnt_q      <= 10'd0;
            sv_q       <= '0;
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            wen_q      <= wen_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            done_q     <= done_d;
            str_addr_q <= str_addr_d;
            cnt_q      <= cnt_d;
            sv_q       <= sv_d;
        end
    end

    always_ff @(posedge clk_in) begin
        row_q  <= row_d;
        col_q  <= col_d;
        arg_q  <= arg_d;
        len_q  <= len_d;
        oob_q  <= oob_d;
        scol_q <= scol_d;
    end

    assign cmd_ready_out      = ready_q;
    assign buf_write_en_out   = wen_q;
    assign buf_write_addr_out = waddr_q;
    assign buf_write_data_out = wdata_q;
    assign done_out           = done_q;
    assign str_addr_out       = str_addr_q;

endmodule

// File: tb/tb_config_buf_writer.sv
// Directed bench for config_buf_writer: table of PUT/DEC vectors plus
// hand-written CLEAR, STRING, clipping and mid-command reset sequences.
module tb_config_buf_writer;

    logic       clk_in = 1'b0;
    logic       rst_n_in = 1'b0;
    logic       cmd_valid_in = 1'b0;
    logic       cmd_ready_out;
    logic [1:0] cmd_op_in = 2'd0;
    logic [4:0] cmd_row_in = 5'd0;
    logic [5:0] cmd_col_in = 6'd0;
    logic [9:0] cmd_arg_in = 10'd0;
    logic [5:0] cmd_len_in = 6'd0;
    logic [9:0] str_addr_out;
    logic [7:0] str_data_in = 8'd0;
    logic [9:0] buf_write_addr_out;
    logic [7:0] buf_write_data_out;
    logic       buf_write_en_out;
    logic       done_out;

    config_buf_writer #(.STR_ROM_LATENCY(2), .BLANK_TILE(8'h20)) dut (
        .clk_in             (clk_in),
        .rst_n_in           (rst_n_in),
        .cmd_valid_in       (cmd_valid_in),
        .cmd_ready_out      (cmd_ready_out),
        .cmd_op_in          (cmd_op_in),
        .cmd_row_in         (cmd_row_in),
        .cmd_col_in         (cmd_col_in),
        .cmd_arg_in         (cmd_arg_in),
        .cmd_len_in         (cmd_len_in),
        .str_addr_out       (str_addr_out),
        .str_data_in        (str_data_in),
        .buf_write_addr_out (buf_write_addr_out),
        .buf_write_data_out (buf_write_data_out),
        .buf_write_en_out   (buf_write_en_out),
        .done_out           (done_out)
    );

    always #5 clk_in = ~clk_in;

    // String ROM with two cycles from address register to captured data.
    logic [7:0] rom [0:1023];
    always @(posedge clk_in) str_data_in <= rom[str_addr_out];

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    int         acc_cyc = 0;
    int         rdy_cyc = -1;
    int         wq_cyc[$];
    logic [9:0] wq_addr[$];
    logic [7:0] wq_data[$];
    int         dq[$];
    logic [9:0] sa_hist[int];

    always @(negedge clk_in) begin
        if (buf_write_en_out) begin
            wq_cyc.push_back(cyc);
            wq_addr.push_back(buf_write_addr_out);
            wq_data.push_back(buf_write_data_out);
        end
        if (done_out) dq.push_back(cyc);
        sa_hist[cyc] = str_addr_out;
        if (cmd_valid_in && cmd_ready_out) begin
            acc_cyc = cyc;
            rdy_cyc = -1;
        end else if (cmd_ready_out && rdy_cyc < 0) begin
            rdy_cyc = cyc;
        end
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic clear_logs();
        wq_cyc.delete();
        wq_addr.delete();
        wq_data.delete();
        dq.delete();
        sa_hist.delete();
    endtask

    task automatic send(input logic [1:0] op, input logic [4:0] row, input logic [5:0] col,
                        input logic [9:0] arg, input logic [5:0] len);
        int b;
        b = 0;
        @(posedge clk_in); #1;
        while (!cmd_ready_out && b < 2000) begin
            @(posedge clk_in); #1;
            b++;
        end
        if (!cmd_ready_out) begin
            chk("send_ready_timeout", 32'(cmd_ready_out), 32'd1);
        end else begin
            clear_logs();
            cmd_op_in    = op;
            cmd_row_in   = row;
            cmd_col_in   = col;
            cmd_arg_in   = arg;
            cmd_len_in   = len;
            cmd_valid_in = 1'b1;
            @(posedge clk_in); #1;
            cmd_valid_in = 1'b0;
        end
    endtask

    task automatic wait_ready(input string name);
        int b;
        b = 0;
        while (rdy_cyc < 0 && b < 3000) begin
            @(negedge clk_in); #1;
            b++;
        end
        chk({name, "_complete"}, 32'(rdy_cyc >= 0), 32'd1);
    endtask

    task automatic check_clear(input string name);
        int bad;
        bad = 0;
        chk({name, "_nwrites"}, wq_addr.size(), 920);
        for (int i = 0; i < wq_addr.size(); i++)
            if (wq_addr[i] != 10'(i) || wq_data[i] != 8'h20 || wq_cyc[i] != acc_cyc + 1 + i) bad++;
        chk({name, "_seq_errors"}, bad, 0);
        chk({name, "_done_count"}, dq.size(), 1);
        if (dq.size() > 0) chk({name, "_done_cycle"}, dq[0] - acc_cyc, 920);
        chk({name, "_ready_cycle"}, rdy_cyc - acc_cyc, 921);
    endtask

    typedef struct {
        string      name;
        logic [1:0] op;
        logic [4:0] row;
        logic [5:0] col;
        logic [9:0] arg;
        int         nw;
        logic [9:0] a0;
        logic [7:0] d [3];
    } vec_t;

    vec_t vecs[10];

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = 8'h00;
        rom[10'h040] = "H"; rom[10'h041] = "E"; rom[10'h042] = "L";
        rom[10'h043] = "L"; rom[10'h044] = "O";
        rom[10'h080] = "A"; rom[10'h081] = "B"; rom[10'h082] = "C";
        rom[10'h083] = "D"; rom[10'h084] = "E"; rom[10'h085] = "F";

        vecs[0] = '{"put_r3c1",     2'd1, 5'd3,  6'd1,  10'h041, 1, 10'd121, '{8'h41, 8'h00, 8'h00}};
        vecs[1] = '{"put_r22c39",   2'd1, 5'd22, 6'd39, 10'h07E, 1, 10'd919, '{8'h7E, 8'h00, 8'h00}};
        vecs[2] = '{"put_row_oob",  2'd1, 5'd23, 6'd0,  10'h055, 0, 10'd0,   '{8'h00, 8'h00, 8'h00}};
        vecs[3] = '{"put_col_oob",  2'd1, 5'd0,  6'd40, 10'h055, 0, 10'd0,   '{8'h00, 8'h00, 8'h00}};
        vecs[4] = '{"dec_0",        2'd3, 5'd5,  6'd10, 10'd0,   3, 10'd210, '{8'h20, 8'h20, 8'h30}};
        vecs[5] = '{"dec_7",        2'd3, 5'd5,  6'd10, 10'd7,   3, 10'd210, '{8'h20, 8'h20, 8'h37}};
        vecs[6] = '{"dec_42",       2'd3, 5'd5,  6'd10, 10'd42,  3, 10'd210, '{8'h20, 8'h34, 8'h32}};
        vecs[7] = '{"dec_255",      2'd3, 5'd5,  6'd10, 10'd255, 3, 10'd210, '{8'h32, 8'h35, 8'h35}};
        vecs[8] = '{"dec_100",      2'd3, 5'd5,  6'd10, 10'd100, 3, 10'd210, '{8'h31, 8'h30, 8'h30}};
        vecs[9] = '{"dec_9_clip",   2'd3, 5'd1,  6'd38, 10'd9,   2, 10'd78,  '{8'h20, 8'h20, 8'h00}};

        // Reset values
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        chk("rst_ready", 32'(cmd_ready_out), 32'd0);
        chk("rst_wen", 32'(buf_write_en_out), 32'd0);
        chk("rst_waddr", 32'(buf_write_addr_out), 32'd0);
        chk("rst_wdata", 32'(buf_write_data_out), 32'd0);
        chk("rst_str_addr", 32'(str_addr_out), 32'd0);
        chk("rst_done", 32'(done_out), 32'd0);
        @(posedge clk_in); #1;
        rst_n_in = 1'b1;
        @(negedge clk_in);
        chk("ready_low_release_cycle", 32'(cmd_ready_out), 32'd0);
        @(negedge clk_in);
        chk("ready_after_release", 32'(cmd_ready_out), 32'd1);

        // Full clear
        send(2'd0, 5'd0, 6'd0, 10'd0, 6'd0);
        wait_ready("clear1");
        check_clear("clear1");

        // Table of PUT and DEC commands
        foreach (vecs[v]) begin
            send(vecs[v].op, vecs[v].row, vecs[v].col, vecs[v].arg, 6'd0);
            wait_ready(vecs[v].name);
            chk({vecs[v].name, "_nwrites"}, wq_addr.size(), vecs[v].nw);
            for (int i = 0; i < wq_addr.size() && i < vecs[v].nw; i++) begin
                chk({vecs[v].name, "_addr"}, wq_addr[i], vecs[v].a0 + 10'(i));
                chk({vecs[v].name, "_data"}, wq_data[i], vecs[v].d[i]);
            end
            chk({vecs[v].name, "_done_count"}, dq.size(), 1);
            if (vecs[v].op == 2'd1) begin
                if (dq.size() > 0) chk({vecs[v].name, "_done_cycle"}, dq[0] - acc_cyc, 1);
                if (wq_cyc.size() > 0) chk({vecs[v].name, "_write_cycle"}, wq_cyc[0] - acc_cyc, 1);
                chk({vecs[v].name, "_ready_cycle"}, rdy_cyc - acc_cyc, 2);
            end else if (wq_cyc.size() > 0) begin
                for (int i = 1; i < wq_cyc.size(); i++)
                    chk({vecs[v].name, "_consecutive"}, wq_cyc[i] - wq_cyc[0], i);
                chk({vecs[v].name, "_latency_ok"},
                    32'((wq_cyc[0] - acc_cyc) >= 2 && (wq_cyc[0] - acc_cyc) <= 14), 32'd1);
                if (dq.size() > 0) chk({vecs[v].name, "_done_with_third"}, dq[0] - wq_cyc[0], 2);
                if (dq.size() > 0) chk({vecs[v].name, "_ready_cycle"}, rdy_cyc - dq[0], 1);
            end
        end

        // STRING "HELLO" at row 20 col 16
        send(2'd2, 5'd20, 6'd16, 10'h040, 6'd5);
        wait_ready("str_hello");
        for (int i = 0; i < 5; i++)
            chk("str_hello_rom_addr", sa_hist.exists(acc_cyc + 1 + i) ? sa_hist[acc_cyc + 1 + i] : 10'h3FF,
                10'h040 + 10'(i));
        chk("str_hello_nwrites", wq_addr.size(), 5);
        for (int i = 0; i < wq_addr.size() && i < 5; i++) begin
            chk("str_hello_addr", wq_addr[i], 10'd816 + 10'(i));
            chk("str_hello_data", wq_data[i], rom[10'h040 + 10'(i)]);
            chk("str_hello_wcycle", wq_cyc[i] - acc_cyc, 3 + i);
        end
        chk("str_hello_done_count", dq.size(), 1);
        if (dq.size() > 0) chk("str_hello_done_cycle", dq[0] - acc_cyc, 7);
        chk("str_hello_ready_cycle", rdy_cyc - acc_cyc, 8);

        // STRING clipped at the right edge
        send(2'd2, 5'd0, 6'd37, 10'h080, 6'd6);
        wait_ready("str_clip");
        chk("str_clip_nwrites", wq_addr.size(), 3);
        for (int i = 0; i < wq_addr.size() && i < 3; i++) begin
            chk("str_clip_addr", wq_addr[i], 10'd37 + 10'(i));
            chk("str_clip_data", wq_data[i], 8'h41 + 8'(i));
        end
        chk("str_clip_done_count", dq.size(), 1);
        if (dq.size() > 0) chk("str_clip_done_cycle", dq[0] - acc_cyc, 8);

        // STRING of length zero
        send(2'd2, 5'd4, 6'd4, 10'h040, 6'd0);
        wait_ready("str_len0");
        chk("str_len0_nwrites", wq_addr.size(), 0);
        chk("str_len0_done_count", dq.size(), 1);
        if (dq.size() > 0) chk("str_len0_done_cycle", dq[0] - acc_cyc, 1);
        chk("str_len0_ready_cycle", rdy_cyc - acc_cyc, 2);

        // Reset in the middle of CLEAR
        send(2'd0, 5'd0, 6'd0, 10'd0, 6'd0);
        begin
            int b;
            b = 0;
            while (wq_addr.size() < 100 && b < 2000) begin
                @(negedge clk_in); #1;
                b++;
            end
        end
        rst_n_in = 1'b0;
        repeat (3) @(negedge clk_in);
        #1;
        chk("midrst_nwrites", wq_addr.size(), 100);
        chk("midrst_done_count", dq.size(), 0);
        chk("midrst_ready", 32'(cmd_ready_out), 32'd0);
        @(posedge clk_in); #1;
        rst_n_in = 1'b1;
        send(2'd0, 5'd0, 6'd0, 10'd0, 6'd0);
        wait_ready("clear2");
        check_clear("clear2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
